// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
package serial_pkg;

   // Transmitter frame states.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // Line levels used while framing.
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Number of clock cycles from the first start-bit cycle to the last stop-bit cycle.
   function automatic int unsigned frame_len(input int unsigned data_w,
                                             input int unsigned clks_per_bit,
                                             input int unsigned parity_en);
      return (32'd2 + data_w + parity_en) * clks_per_bit;
   endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel-word handshake into the serial frame transmitter.
interface serial_frame_tx_if #(
   parameter int DATA_W = 8
) ();

   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;

   // Word source side.
   modport master (output din, output din_valid, input din_ready);
   // Transmitter side.
   modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last count.
// Held at zero whenever disabled, so a frame always starts on a fresh bit period.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int TW = $clog2(CLKS_PER_BIT) + 1;

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   assign tick = en && (cnt_q == TW'(CLKS_PER_BIT - 1));

   // Next count: clear when idle or at the end of a bit period, else increment.
   always_comb begin
      cnt_d = cnt_q;
      if (!en) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// All outputs come straight from flops; the next output is derived from the next state.
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic             clk,
   input  logic             reset,
   serial_frame_tx_if.slave bus,
   output logic             out,
   output logic             busy,
   output logic             done
);

   localparam int BCW = $clog2(DATA_W + 1);

   tx_state_t         state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              par_q, par_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic              out_q, out_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ready_q, ready_d;
   logic              accept;
   logic              tick;

   // Even parity over the captured word.
   function automatic logic even_par(input logic [DATA_W-1:0] w);
      return ^w;
   endfunction

   assign accept = bus.din_valid && ready_q;

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk   (clk),
      .reset (reset),
      .en    (state_q != IDLE),
      .tick  (tick)
   );

   // Frame sequencing: next state, shift register, parity and bit counter.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = START;
               shreg_d   = bus.din;
               par_d     = even_par(bus.din);
               bit_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == BCW'(DATA_W - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end else begin
               shreg_d = shreg_q;
            end
         end
         PARITY: begin
            if (tick) begin
               state_d = STOP;
            end else begin
               state_d = PARITY;
            end
         end
         STOP: begin
            if (tick) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered line level and status, looked up from the state being entered.
   always_comb begin
      out_d = LINE_IDLE;
      case (state_d)
         IDLE:    out_d = LINE_IDLE;
         START:   out_d = START_BIT;
         DATA:    out_d = shreg_d[0];
         PARITY:  out_d = par_d;
         STOP:    out_d = STOP_BIT;
         default: out_d = LINE_IDLE;
      endcase
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
   end

   // State and output registers with synchronous active-low reset; reset abandons any frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         bit_cnt_q <= '0;
         out_q     <= LINE_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         bit_cnt_q <= bit_cnt_d;
         out_q     <= out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
      end
   end

   assign out           = out_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign bus.din_ready = ready_q;

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: accepts a parallel word over a valid/ready handshake and drives it onto a single-bit line as a framed serial stream (start bit, data LSB-first, optional even parity, stop bit). It is the transmit end of the team's serial-bit datapath and feeds the single-bit `in` of the serial receiver/detector blocks in the flip-flop lab designs. The line idles high.

## Interface
- `DATA_W`, 8: data bits per frame (1–16).
- `CLKS_PER_BIT`, 4: clock cycles each serial bit is held (≥1).
- `PARITY_EN`, 1: 1 = append even-parity bit; 0 = no parity bit.

- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `din` input DATA_W: word to transmit; sampled only on acceptance.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: block can accept a word.
- `out` output 1: serial line.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse when a frame completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset (`reset`=0 at an edge): state=IDLE, `out`=1, `din_ready`=1, `busy`=0, `done`=0, bit counter and timer cleared.
- IDLE: `out`=1, `din_ready`=1. Acceptance is `din_valid`&&`din_ready` at an edge. On acceptance, `din` is captured into the shift register and the state goes to START.
- START: `out`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `out`=shreg[0]. The register shifts right every CLKS_PER_BIT cycles. After DATA_W bits, the state goes to PARITY if PARITY_EN, else STOP.
- PARITY: `out`=XOR of the captured word (even parity), held CLKS_PER_BIT cycles.
- STOP: `out`=1 for CLKS_PER_BIT cycles, then IDLE.
- `busy`=1 in every state except IDLE. `din_ready`=(state==IDLE).
- `done`=1 for exactly the one cycle after the STOP→IDLE transition. `din_ready` is also 1 in that cycle, so a new word may be accepted in the same cycle.
- While busy, `din` and `din_valid` are ignored. The transmitted word never changes mid-frame.
- Reset mid-frame: the frame is abandoned. `out` returns to 1 at that edge and no `done` is generated.
- All outputs are registered. Nothing combinational runs from the inputs to `out`.

## Timing
- Frame length F = (1 + DATA_W + PARITY_EN + 1) × CLKS_PER_BIT cycles.
- Cycle numbering: acceptance edge = edge 0. The start bit occupies cycles 1..CLKS_PER_BIT. Bit k occupies cycles k×CLKS_PER_BIT+1 .. (k+1)×CLKS_PER_BIT, where k counts the start bit as 0. `done` is high in cycle F+1.
- Minimum spacing of back-to-back frames is F+1 cycles, i.e. one high idle cycle between the stop bit and the next start bit.
- Bit timer: a counter from 0 to CLKS_PER_BIT−1 that wraps. The tick occurs at CLKS_PER_BIT−1. With CLKS_PER_BIT=1 it ticks every cycle.
- Width rules:
  - Bit counter is $clog2(DATA_W+1) bits.
  - Timer is $clog2(CLKS_PER_BIT)+1 bits.
  - No overflow is permitted at any parameter value in range.

## Structure
- Package `serial_pkg` holds:
  - the state enum `tx_state_t` (IDLE/START/DATA/PARITY/STOP);
  - constants `LINE_IDLE`=1'b1, `START_BIT`=1'b0 and `STOP_BIT`=1'b1;
  - a function computing the frame length F.
- Sub-module `bit_timer` takes parameter CLKS_PER_BIT and has ports clk, reset, en, tick. It is cleared on acceptance and on reset.
- The top level holds the FSM, the shift register, the parity register and the output register.

## Test plan
All scenarios use DATA_W=8, CLKS_PER_BIT=4 and PARITY_EN=1 unless stated otherwise.

- Hold `reset`=0 for 2 cycles → `out`=1, `din_ready`=1, `busy`=0, `done`=0. Then release with no valid → line stays 1.
- Send 8'hA5 → `out` sequence is 0, 1,0,1,0,0,1,0,1, 0 (parity), 1, each bit held 4 cycles (44 cycles). `busy`=1 for cycles 1–44, `done`=1 only in cycle 45.
- Hold `din_valid`=1 with 8'h01 then 8'hFF → the second start bit begins in cycle 46. Parity bits are 1 and 0 respectively. Exactly two `done` pulses occur.
- Assert `reset`=0 for one edge at cycle 20 of an 8'h3C frame → `out`=1 from that edge, no `done`, `din_ready`=1. A following 8'h3C then transmits correctly with parity 0.
- Toggle `din` and pulse `din_valid` during a frame of 8'h5A → `din_ready`=0 throughout and the transmitted bits equal 8'h5A.
- With CLKS_PER_BIT=1 and PARITY_EN=0, send 8'h80 → a 10-cycle frame 0,0,0,0,0,0,0,0,1,1, with `done` in cycle 11.
